// File: rtl/poly_synth_pkg.sv
// Shared types and width helpers for the polyphonic tone generator.
// Waveform and FSM encodings live here so the top, interface and shaper agree.
package poly_synth_pkg;

    typedef enum logic [1:0] {
        SQUARE = 2'b00,
        SAW    = 2'b01,
        TRI    = 2'b10,
        MUTE   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LATCH  = 2'b01,
        ACCUM  = 2'b10,
        OUTPUT = 2'b11
    } state_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n) + 32'sd1;
    endfunction

    // Mixing N voices of OUT_W bits each needs clog2(N) headroom bits.
    function automatic int acc_w(input int out_w, input int n);
        return out_w + $clog2(n);
    endfunction

endpackage

// File: rtl/poly_synth_if.sv
// Key, tuning and sample bus between the key scanner, poly_synth and the DAC stage.
interface poly_synth_if #(
    parameter int N_KEYS  = 8,
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 8
);
    import poly_synth_pkg::*;

    logic [N_KEYS-1:0]            keys;
    mode_t                        mode;
    logic                         tune_we;
    logic [idx_w(N_KEYS)-1:0]     tune_addr;
    logic [PHASE_W-1:0]           tune_data;
    logic [OUT_W-1:0]             wave;
    logic                         wave_valid;
    logic [cnt_w(N_KEYS)-1:0]     active_cnt;

    modport master (
        output keys, mode, tune_we, tune_addr, tune_data,
        input  wave, wave_valid, active_cnt
    );

    modport slave (
        input  keys, mode, tune_we, tune_addr, tune_data,
        output wave, wave_valid, active_cnt
    );

endinterface

// File: rtl/voice_shaper.sv
// Combinational waveform shaper: maps one voice's phase to an OUT_W sample.
module voice_shaper
    import poly_synth_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 8
) (
    input  logic [PHASE_W-1:0] phase,
    input  mode_t              mode,
    output logic [OUT_W-1:0]   sample
);

    logic [OUT_W-1:0] top_s;
    logic [OUT_W-1:0] tri_s;
    logic             msb_s;
    logic             unused_phase_s;

    assign top_s          = phase[PHASE_W-1 -: OUT_W];
    assign msb_s          = phase[PHASE_W-1];
    // Triangle folds the second half of the cycle back down by inversion.
    assign tri_s          = {top_s[OUT_W-2:0], 1'b0};
    assign unused_phase_s = ^phase;

    // Waveform selection
    always_comb begin
        sample = '0;
        case (mode)
            SQUARE: begin
                if (msb_s) sample = '1;
                else       sample = '0;
            end
            SAW:    sample = top_s;
            TRI: begin
                if (msb_s) sample = ~tri_s;
                else       sample = tri_s;
            end
            MUTE:    sample = '0;
            default: sample = '0;
        endcase
    end

endmodule

// File: rtl/poly_synth.sv
// Polyphonic tone generator: per-key phase accumulators mixed by one
// time-multiplexed accumulator into a single sample per sample period.
module poly_synth
    import poly_synth_pkg::*;
#(
    parameter int N_KEYS     = 8,
    parameter int PHASE_W    = 16,
    parameter int OUT_W      = 8,
    parameter int SAMPLE_DIV = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    poly_synth_if.slave  bus
);

    localparam int IDX_W = idx_w(N_KEYS);
    localparam int CNT_W = cnt_w(N_KEYS);
    localparam int ACC_W = acc_w(OUT_W, N_KEYS);
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    logic [N_KEYS-1:0]  key_meta_r;
    logic [N_KEYS-1:0]  key_sync_r;
    logic [N_KEYS-1:0]  keys_lat_r;
    mode_t              mode_lat_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic               tick_s;
    state_t             state_r;
    state_t             next_state_s;
    logic               latch_en_s;
    logic               accum_en_s;
    logic               output_en_s;
    logic [IDX_W-1:0]   vidx_r;
    logic               last_voice_s;
    logic [ACC_W-1:0]   acc_r;
    logic [PHASE_W-1:0] phase_r [N_KEYS];
    logic [PHASE_W-1:0] tune_r  [N_KEYS];
    logic [PHASE_W-1:0] new_phase_s;
    logic [OUT_W-1:0]   shaped_s;
    logic               voice_on_s;
    logic [CNT_W-1:0]   pop_s;
    logic [OUT_W-1:0]   wave_r;
    logic               wave_valid_r;
    logic [CNT_W-1:0]   active_cnt_r;

    // Two-flop synchroniser for the asynchronous key levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_r <= '0;
            key_sync_r <= '0;
        end else begin
            key_meta_r <= bus.keys;
            key_sync_r <= key_meta_r;
        end
    end

    assign tick_s = (div_cnt_r == DIV_W'(SAMPLE_DIV - 1));

    // Free-running sample-period divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      div_cnt_r <= '0;
        else if (tick_s) div_cnt_r <= '0;
        else             div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    assign last_voice_s = (vidx_r == IDX_W'(N_KEYS - 1));

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (tick_s) next_state_s = LATCH;
                else        next_state_s = IDLE;
            end
            LATCH: next_state_s = ACCUM;
            ACCUM: begin
                if (last_voice_s) next_state_s = OUTPUT;
                else              next_state_s = ACCUM;
            end
            OUTPUT:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM output decode into datapath strobes
    always_comb begin
        latch_en_s  = 1'b0;
        accum_en_s  = 1'b0;
        output_en_s = 1'b0;
        case (state_r)
            LATCH:   latch_en_s  = 1'b1;
            ACCUM:   accum_en_s  = 1'b1;
            OUTPUT:  output_en_s = 1'b1;
            default: latch_en_s  = 1'b0;
        endcase
    end

    // Reads use the registered tune word, so a same-cycle write lands next sample.
    assign voice_on_s  = keys_lat_r[vidx_r];
    assign new_phase_s = phase_r[vidx_r] + tune_r[vidx_r];

    voice_shaper #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_shaper (
        .phase  (new_phase_s),
        .mode   (mode_lat_r),
        .sample (shaped_s)
    );

    // Sample latch, voice index and mix accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_lat_r <= '0;
            mode_lat_r <= SQUARE;
            vidx_r     <= '0;
            acc_r      <= '0;
        end else if (latch_en_s) begin
            keys_lat_r <= key_sync_r;
            mode_lat_r <= bus.mode;
            vidx_r     <= '0;
            acc_r      <= '0;
        end else if (accum_en_s) begin
            vidx_r <= vidx_r + IDX_W'(1'b1);
            if (voice_on_s) acc_r <= acc_r + ACC_W'(shaped_s);
        end
    end

    // Per-voice phase; released voices restart from zero on the next press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_KEYS; i++) phase_r[i] <= '0;
        end else if (accum_en_s) begin
            if (voice_on_s) phase_r[vidx_r] <= new_phase_s;
            else            phase_r[vidx_r] <= '0;
        end
    end

    // Tuning word RAM, writable in any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_KEYS; i++) tune_r[i] <= '0;
        end else if (bus.tune_we) begin
            tune_r[bus.tune_addr] <= bus.tune_data;
        end
    end

    // Number of keys held in the latched sample
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < N_KEYS; i++) pop_s = pop_s + CNT_W'(keys_lat_r[i]);
    end

    // Registered sample outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_r       <= '0;
            wave_valid_r <= 1'b0;
            active_cnt_r <= '0;
        end else begin
            wave_valid_r <= output_en_s;
            if (output_en_s) begin
                wave_r       <= acc_r[ACC_W-1:IDX_W];
                active_cnt_r <= pop_s;
            end
        end
    end

    assign bus.wave       = wave_r;
    assign bus.wave_valid = wave_valid_r;
    assign bus.active_cnt = active_cnt_r;

endmodule

// File: tb/tb_poly_synth.sv
// Self-checking bench for poly_synth (N_KEYS=8, PHASE_W=16, OUT_W=8, SAMPLE_DIV=16)
// against an arithmetic per-sample model of the voices.
module tb_poly_synth;
    import poly_synth_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int    ref_phase [8];
    int    ref_tune  [8];
    logic [7:0] m_keys;
    mode_t      m_mode;

    poly_synth_if #(.N_KEYS(8), .PHASE_W(16), .OUT_W(8)) bus ();

    poly_synth #(.N_KEYS(8), .PHASE_W(16), .OUT_W(8), .SAMPLE_DIV(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int shape(input int ph, input mode_t md);
        int t;
        int u;
        t = ph / 256;
        u = (t * 2) % 256;
        case (md)
            SQUARE:  return (ph >= 32768) ? 255 : 0;
            SAW:     return t;
            TRI:     return (ph >= 32768) ? 255 - u : u;
            default: return 0;
        endcase
    endfunction

    task automatic set_inputs(input logic [7:0] k, input mode_t md);
        bus.keys = k;
        bus.mode = md;
        m_keys   = k;
        m_mode   = md;
    endtask

    task automatic write_tune(input int a, input int d);
        bus.tune_addr = 3'(a);
        bus.tune_data = 16'(d);
        bus.tune_we   = 1'b1;
        @(posedge clk);
        ref_tune[a] = d;
        @(negedge clk);
        bus.tune_we = 1'b0;
    endtask

    // Advance the model one sample, then wait (bounded) for the DUT's next sample.
    task automatic next_sample(output logic [7:0] gw, output logic [3:0] gc,
                               output int ew, output int ec, output bit to);
        int sum = 0;
        ec = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_keys[i]) begin
                ref_phase[i] = (ref_phase[i] + ref_tune[i]) % 65536;
                sum += shape(ref_phase[i], m_mode);
                ec++;
            end else begin
                ref_phase[i] = 0;
            end
        end
        ew = sum / 8;
        to = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (bus.wave_valid === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        gw = bus.wave;
        gc = bus.active_cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(8'h00, SQUARE);
        bus.tune_we = 1'b0; bus.tune_addr = 3'd0; bus.tune_data = 16'h0000;
        for (int i = 0; i < 8; i++) begin ref_phase[i] = 0; ref_tune[i] = 0; end
        repeat (3) @(negedge clk);
        checks++; if (bus.wave !== 8'h00) begin errors++; $display("FAIL reset_wave: got %0d expected 0", bus.wave); end
        checks++; if (bus.wave_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.wave_valid); end
        checks++; if (bus.active_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.active_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_cadence();
        logic [7:0] gw; logic [3:0] gc; int ew, ec; bit to; int t0;
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== 8'd0) begin errors++; $display("FAIL cadence_wave: got %0d expected 0 (timeout=%0d)", gw, to); end
        t0 = cyc;
        @(negedge clk);
        checks++; if (bus.wave_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b expected 0", bus.wave_valid); end
        for (int k = 0; k < 2; k++) begin
            next_sample(gw, gc, ew, ec, to);
            checks++; if (to || (cyc - t0) != 16) begin errors++; $display("FAIL cadence_period: got %0d expected 16", cyc - t0); end
            t0 = cyc;
        end
    endtask

    task automatic test_square();
        logic [7:0] gw; logic [3:0] gc; int ew, ec; bit to;
        int sq_exp [6] = '{0, 31, 31, 0, 0, 31};
        write_tune(0, 16'h4000);
        next_sample(gw, gc, ew, ec, to);
        set_inputs(8'h01, SQUARE);
        for (int k = 0; k < 6; k++) begin
            next_sample(gw, gc, ew, ec, to);
            checks++; if (to || gw !== sq_exp[k]) begin errors++; $display("FAIL square_%0d: got %0d expected %0d", k, gw, sq_exp[k]); end
            checks++; if (gc !== 4'd1) begin errors++; $display("FAIL square_cnt_%0d: got %0d expected 1", k, gc); end
        end
    endtask

    task automatic test_release_mute();
        logic [7:0] gw; logic [3:0] gc; int ew, ec; bit to;
        set_inputs(8'h01, SAW);
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== ew) begin errors++; $display("FAIL saw_hold: got %0d expected %0d", gw, ew); end
        set_inputs(8'h00, SAW);
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== 8'd0 || gc !== 4'd0) begin errors++; $display("FAIL release: got %0d/%0d expected 0/0", gw, gc); end
        set_inputs(8'h01, SAW);
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== 8'd8) begin errors++; $display("FAIL retrigger_1: got %0d expected 8", gw); end
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== 8'd16) begin errors++; $display("FAIL retrigger_2: got %0d expected 16", gw); end
        set_inputs(8'h01, MUTE);
        for (int k = 0; k < 2; k++) begin
            next_sample(gw, gc, ew, ec, to);
            checks++; if (to || gw !== 8'd0 || gc !== 4'd1) begin errors++; $display("FAIL mute_%0d: got %0d/%0d expected 0/1", k, gw, gc); end
        end
        set_inputs(8'h01, SAW);
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== ew) begin errors++; $display("FAIL after_mute: got %0d expected %0d", gw, ew); end
    endtask

    task automatic test_saw_chord();
        logic [7:0] gw; logic [3:0] gc; int ew, ec; bit to;
        set_inputs(8'h00, SAW);
        next_sample(gw, gc, ew, ec, to);
        for (int i = 0; i < 8; i++) write_tune(i, 16'h1000);
        next_sample(gw, gc, ew, ec, to);
        set_inputs(8'hFF, SAW);
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== 8'd16 || gc !== 4'd8) begin errors++; $display("FAIL chord_1: got %0d/%0d expected 16/8", gw, gc); end
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== 8'd32 || gc !== 4'd8) begin errors++; $display("FAIL chord_2: got %0d/%0d expected 32/8", gw, gc); end
    endtask

    task automatic test_triangle();
        logic [7:0] gw; logic [3:0] gc; int ew, ec; bit to;
        int tri_exp [5] = '{8, 16, 24, 31, 23};
        set_inputs(8'h00, TRI);
        next_sample(gw, gc, ew, ec, to);
        write_tune(3, 16'h2000);
        next_sample(gw, gc, ew, ec, to);
        set_inputs(8'h08, TRI);
        for (int k = 0; k < 5; k++) begin
            next_sample(gw, gc, ew, ec, to);
            checks++; if (to || gw !== tri_exp[k] || gc !== 4'd1) begin errors++; $display("FAIL triangle_%0d: got %0d/%0d expected %0d/1", k, gw, gc, tri_exp[k]); end
        end
    endtask

    task automatic test_collision();
        logic [7:0] gw; logic [3:0] gc; int ew, ec; bit to;
        set_inputs(8'h00, SAW);
        next_sample(gw, gc, ew, ec, to);
        write_tune(2, 16'h1000);
        next_sample(gw, gc, ew, ec, to);
        set_inputs(8'h04, SAW);
        // Voice 2 is accumulated on the 10th edge after the previous sample's valid edge.
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.tune_addr = 3'd2; bus.tune_data = 16'h3000; bus.tune_we = 1'b1;
        @(negedge clk);
        bus.tune_we = 1'b0;
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== 8'd2) begin errors++; $display("FAIL collision_old: got %0d expected 2", gw); end
        ref_tune[2] = 16'h3000;
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== 8'd8) begin errors++; $display("FAIL collision_new: got %0d expected 8", gw); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] gw; logic [3:0] gc; int ew, ec; bit to; int seen;
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== ew) begin errors++; $display("FAIL pre_reset: got %0d expected %0d", gw, ew); end
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wave !== 8'd0 || bus.wave_valid !== 1'b0 || bus.active_cnt !== 4'd0) begin
            errors++; $display("FAIL midreset_outputs: got %0d/%b/%0d expected 0/0/0", bus.wave, bus.wave_valid, bus.active_cnt);
        end
        set_inputs(8'h00, SAW);
        for (int i = 0; i < 8; i++) begin ref_phase[i] = 0; ref_tune[i] = 0; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.wave_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL aborted_sample_valid: got %0d pulses expected 0", seen); end
        next_sample(gw, gc, ew, ec, to);
        write_tune(2, 16'h2000);
        next_sample(gw, gc, ew, ec, to);
        set_inputs(8'h24, SAW);
        next_sample(gw, gc, ew, ec, to);
        checks++; if (to || gw !== 8'd4 || gc !== 4'd2) begin errors++; $display("FAIL post_reset_restart: got %0d/%0d expected 4/2", gw, gc); end
    endtask

    task automatic test_random();
        logic [7:0] gw; logic [3:0] gc; int ew, ec; bit to;
        set_inputs(8'h00, SAW);
        next_sample(gw, gc, ew, ec, to);
        for (int i = 0; i < 8; i++) write_tune(i, int'($urandom_range(0, 65535)));
        next_sample(gw, gc, ew, ec, to);
        for (int k = 0; k < 16; k++) begin
            set_inputs(8'($urandom_range(0, 255)), mode_t'($urandom_range(0, 3)));
            next_sample(gw, gc, ew, ec, to);
            checks++; if (to || gw !== ew) begin errors++; $display("FAIL random_wave_%0d: got %0d expected %0d", k, gw, ew); end
            checks++; if (gc !== ec) begin errors++; $display("FAIL random_cnt_%0d: got %0d expected %0d", k, gc, ec); end
        end
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_square();
        test_release_mute();
        test_saw_chord();
        test_triangle();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/poly_synth.md
# poly_synth

Parametrised polyphonic tone generator, successor to the fixed eight-key piano datapath. Each key drives its own phase-accumulator voice with a run-time programmable tuning word. One time-multiplexed accumulator mixes all voices into a single unsigned sample per sample period, using a selectable waveform (square, saw, triangle). The block sits between the key inputs and the audio DAC/PWM stage; `wave` and `wave_valid` feed that stage directly.

## Interface
- `N_KEYS`, default 8: number of keys/voices; must be a power of two, ≥2.
- `PHASE_W`, default 16: phase accumulator and tuning word width.
- `OUT_W`, default 8: sample width; must be ≤ PHASE_W.
- `SAMPLE_DIV`, default 256: clk cycles per sample period; must be ≥ N_KEYS+3.
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `keys`  in  N_KEYS: raw key levels; bit i = key i pressed; asynchronous to clk.
- `mode`  in  2: waveform select, 00 square, 01 saw, 10 triangle, 11 mute.
- `tune_we`  in  1: tuning-word write strobe.
- `tune_addr`  in  clog2(N_KEYS): voice index for the write.
- `tune_data`  in  PHASE_W: tuning word (phase increment per sample).
- `wave`  out  OUT_W: mixed sample; held between updates.
- `wave_valid`  out  1: one-cycle pulse when `wave` updates.
- `active_cnt`  out  clog2(N_KEYS)+1: number of keys pressed in the last latched sample.

## Operation
- `keys` pass through a 2-flop synchroniser. Only synchronised values are used.
- Free-running divider `div_cnt` counts 0..SAMPLE_DIV-1 and wraps. `tick` asserts when `div_cnt` == SAMPLE_DIV-1.
- FSM states:
  - IDLE: on `tick`, go to LATCH.
  - LATCH (1 cycle): capture synchronised keys and `mode`, clear the mix accumulator, set voice index to 0; go to ACCUM.
  - ACCUM (N_KEYS cycles), per voice i:
    - If key i is latched pressed: `phase[i] <= phase[i] + tune[i]`, with mod 2^PHASE_W wrap. Shape the updated phase and add the shaped value to the accumulator.
    - If key i is not pressed: `phase[i] <= 0`, so the next press restarts at phase 0, and the voice adds 0.
    - Go to OUTPUT after voice N_KEYS-1.
  - OUTPUT (1 cycle): `wave <= acc >> clog2(N_KEYS)`, `wave_valid <= 1`, `active_cnt <=` popcount of latched keys; go to IDLE.
- Shaping, with t = top OUT_W bits of the phase and m = phase MSB:
  - square: all-ones if m, else 0.
  - saw: t.
  - triangle: u = {t[OUT_W-2:0],1'b0}; result is ~u if m, else u.
  - mute: 0. Phases still advance and `active_cnt` still counts.
- Accumulator width is OUT_W+clog2(N_KEYS). It cannot overflow, so no saturation is needed.
- Tuning RAM: N_KEYS × PHASE_W registers, written whenever `tune_we`=1, in any state.
  - A write to voice i in the same cycle ACCUM reads voice i: ACCUM uses the old value; the new value applies from the next sample.
- `keys` and `mode` changes outside LATCH have no effect until the next LATCH.

## Timing
- Reset values (asynchronous): `wave`=0, `wave_valid`=0, `active_cnt`=0, all phases 0, all tuning words 0, `div_cnt`=0, FSM=IDLE, synchroniser flops 0.
- `wave_valid` rises N_KEYS+2 cycles after the `tick` cycle (LATCH, then N_KEYS ACCUM cycles, then OUTPUT), and recurs exactly every SAMPLE_DIV cycles.
- Key-to-output latency is 2 synchroniser cycles plus up to one sample period.
- Reset asserted mid-ACCUM aborts the sample: no `wave_valid`, and all state returns to reset values.
- After reset release, the first `tick` occurs SAMPLE_DIV cycles after the first clk edge with `rst_n` high.

## Structure
- Package `poly_synth_pkg` holds:
  - the `mode_t` encoding (SQUARE, SAW, TRI, MUTE);
  - the FSM `state_t` (IDLE, LATCH, ACCUM, OUTPUT);
  - the `clog2`-derived width helpers.
- One sub-module, `voice_shaper`: combinational phase + mode → OUT_W sample, parametrised on PHASE_W and OUT_W.
- The divider, FSM, phase/tune arrays and accumulator stay in `poly_synth`.

## Test plan
All scenarios use N_KEYS=8, PHASE_W=16, OUT_W=8, SAMPLE_DIV=16.
- Reset and cadence: hold `rst_n`=0 → `wave`=0, `wave_valid`=0, `active_cnt`=0. After release with no keys → `wave_valid` pulses every 16 cycles with `wave`=0.
- Square, one voice: tune[0]=0x4000, key0 held, mode 00 → successive `wave` = 0, 31, 31, 0, 0, 31…, `active_cnt`=1.
- Saw, full chord: all tune words=0x1000, all keys held, mode 01 → first `wave`=16, second 32, `active_cnt`=8.
- Triangle: tune[3]=0x2000, key3 held, mode 10 → samples 1–5 = 8, 16, 24, 31, 23 (phase 0xA000 → 191>>3).
- Release/retrigger and mute:
  - Release key0 mid-note → its next contribution is 0 and its phase returns to 0; re-press → sequence restarts from the first value.
  - mode 11 with keys held → `wave`=0, `active_cnt` unchanged.
- Collisions and reset: `tune_we` to voice 2 during voice 2's ACCUM cycle → old increment used for that sample, new one for the next. Pulse `rst_n` low during ACCUM → no `wave_valid`, all outputs 0.
